eviction_writeback_buffer: RTL and testbench
============================================

Name: eviction_writeback_buffer

Overview:
- Controller and drain engine for the victim/write-back storage used on L1 evictions.
- Accepts dirty evicted lines from the L1 cache controller and queues them in FIFO order.
- Writes each queued line back to physical memory over the pmem handshake.
- Supplies a lookup port so an L1 miss can be served from a not-yet-drained line instead of from stale memory.

Parameters:
- DEPTH, 8, number of buffered lines; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- evict_valid  in  1  L1 presents an evicted dirty line.
- evict_addr  in  16  line address; bits [3:0] are ignored.
- evict_data  in  128  line data.
- evict_ready  out  1  buffer can accept an eviction this cycle.
- lookup_addr  in  16  L1 miss address; bits [3:0] are ignored.
- lookup_hit  out  1  combinational; a matching valid line is buffered.
- lookup_data  out  128  combinational; data of the matching line.
- pmem_address  out  16  write-back address, {tag, 4'b0}.
- pmem_wdata  out  128  write-back data.
- pmem_write  out  1  write-back request.
- pmem_resp  in  1  memory has completed the write.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (reset_n low at posedge):
  - head, tail and count go to 0; all valid bits clear; FSM goes to IDLE.
  - Outputs after reset: pmem_write=0, lookup_hit=0, empty=1, full=0, evict_ready=1.
  - Reset mid-write drops pmem_write the following cycle and discards all buffered lines.
- Entry format: {tag[11:0]=addr[15:4], data[127:0]}, held per slot. Valid bits are owned by this block, not by storage.
- evict_ready = !full. Full is derived from registered count only; there is no same-cycle bypass from a pop.
- Enqueue, on posedge with evict_valid && evict_ready:
  - Merge: if the tag matches a valid slot that is not the slot currently in WRITE, overwrite that slot's data in place. tail and count are unchanged.
  - Otherwise: write to the slot at tail, set its valid bit, tail+1 mod DEPTH, count+1.
  - A match against the in-flight head slot always allocates a new slot. pmem_wdata must stay stable during WRITE.
- Lookup:
  - Purely combinational over all valid slots.
  - If several slots match (in-flight head plus newer copy), the youngest by age from head wins.
  - An enqueue in cycle N is visible to lookup in cycle N+1. A merge becomes visible the same way.
- Drain FSM:
  - IDLE: if count != 0, go to WRITE next cycle.
  - WRITE: pmem_write=1, with pmem_address/pmem_wdata taken from the head slot and held stable.
    - On pmem_resp: clear head valid, head+1 mod DEPTH, count-1, go to IDLE.
    - Each write-back therefore costs one idle bubble cycle before the next begins.
- Simultaneous allocate and pop in one cycle: count is unchanged, and both pointers advance.
- Pointer wrap-around is modulo DEPTH. count is PTR_W+1 bits wide, so full is distinguishable from empty.
- pmem_resp arriving outside WRITE is ignored.

Decomposition:
- Add to package lc3b_types:
  - lc3b_c_tag (12 bits) and lc3b_c_line (128 bits).
  - lc3b_wb_entry struct {tag, data}.
  - FSM enum lc3b_wb_state {WB_IDLE, WB_WRITE}.
- Storage sub-module: the existing array_fully_associative, instantiated with size=DEPTH and write index = tail or the merge slot.
  - Because that array has no reset, valid bits and ages live in this block.
  - The tag compare and priority select form an internal function, not a separate module.

Test Plan:
- Reset, then single eviction: enqueue addr 16'h1230 with data 128'hA5… → next cycle lookup 16'h1234 gives hit=1 with that data. Cycle after that: pmem_write=1, pmem_address=16'h1230. After pmem_resp: empty=1 and lookup_hit=0.
- Fill to DEPTH=8 with pmem_resp held low → full=1 and evict_ready=0. A 9th evict_valid is not accepted and count stays 8. One pmem_resp frees exactly one slot.
- Merge: enqueue 16'h2000 and 16'h3000; while 16'h2000 is in WRITE, enqueue 16'h3000 with new data → count stays 2 and lookup gets the new data. Enqueue 16'h2000 again → count goes to 3, lookup returns the newest copy, and pmem_wdata is unchanged.
- Simultaneous: count=3, then evict_valid and pmem_resp in the same cycle → count stays 3. Drain all; pointer wrap is verified after 12 enqueue/drain pairs, with addresses written in FIFO order.
- Reset mid-WRITE: reset_n low while pmem_write=1 → next cycle pmem_write=0, empty=1, lookup_hit=0 for all previously buffered addresses.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared cache types for the LC-3b memory hierarchy, including the
// write-back buffer entry and its drain FSM states.
package lc3b_types;

  typedef logic [11:0]  lc3b_c_tag;
  typedef logic [127:0] lc3b_c_line;

  typedef struct packed {
    lc3b_c_tag  tag;
    lc3b_c_line data;
  } lc3b_wb_entry;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } lc3b_wb_state;

  localparam int WB_ENTRY_W = $bits(lc3b_wb_entry);

endpackage

// File: rtl/array_fully_associative.sv
// Unreset storage array with one indexed write port and every slot visible
// at once, so callers can search all entries in parallel.
module array_fully_associative #(
  parameter int size  = 8,
  parameter int width = 140
) (
  input  logic                         clk,
  input  logic                         load,
  input  logic [$clog2(size)-1:0]      index,
  input  logic [width-1:0]             datain,
  output logic [size-1:0][width-1:0]   dataout
);

  logic [size-1:0][width-1:0] data;

  always_ff @(posedge clk) begin
    if (load) begin
      data[index] <= datain;
    end
  end

  assign dataout = data;

endmodule

// File: rtl/eviction_writeback_buffer.sv
// FIFO of dirty L1 victims drained to physical memory one line at a time,
// with a combinational lookup so misses can hit on not-yet-written lines.
module eviction_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          evict_valid,
  input  logic [15:0]   evict_addr,
  input  logic [127:0]  evict_data,
  output logic          evict_ready,
  input  logic [15:0]   lookup_addr,
  output logic          lookup_hit,
  output logic [127:0]  lookup_data,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  output logic          pmem_write,
  input  logic          pmem_resp,
  output logic          empty,
  output logic          full
);

  typedef struct packed {
    logic             hit;
    logic [PTR_W-1:0] idx;
  } match_t;

  lc3b_wb_state state, state_next;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] merge_live;
  logic [DEPTH-1:0][WB_ENTRY_W-1:0] slots;

  match_t       merge_m, lookup_m;
  lc3b_wb_entry store_entry, head_entry, lookup_entry;
  logic [PTR_W-1:0] store_index;
  logic accept, do_merge, alloc, pop;
  logic unused_addr_bits;

  // Walks slots oldest-to-youngest from head so the last match is the youngest.
  function automatic match_t find_line(
    input lc3b_c_tag                          tag,
    input logic [DEPTH-1:0]                   live,
    input logic [DEPTH-1:0][WB_ENTRY_W-1:0]   entries,
    input logic [PTR_W-1:0]                   start
  );
    match_t           m;
    logic [PTR_W-1:0] slot;
    lc3b_wb_entry     e;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = start + PTR_W'(i);
      e    = lc3b_wb_entry'(entries[slot]);
      if (live[slot] && e.tag == tag) begin
        m.hit = 1'b1;
        m.idx = slot;
      end
    end
    return m;
  endfunction

  assign unused_addr_bits = ^{evict_addr[3:0], lookup_addr[3:0]};

  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign evict_ready = !full;

  // The in-flight head must not be merged into, or pmem_wdata would change mid-write.
  always_comb begin
    merge_live = valid;
    if (state == WB_WRITE) begin
      merge_live[head] = 1'b0;
    end
  end

  assign merge_m  = find_line(evict_addr[15:4], merge_live, slots, head);
  assign lookup_m = find_line(lookup_addr[15:4], valid, slots, head);

  assign accept      = evict_valid && evict_ready;
  assign do_merge    = accept && merge_m.hit;
  assign alloc       = accept && !merge_m.hit;
  assign pop         = (state == WB_WRITE) && pmem_resp;
  assign store_index = do_merge ? merge_m.idx : tail;
  assign store_entry = '{tag: evict_addr[15:4], data: evict_data};

  array_fully_associative #(
    .size  (DEPTH),
    .width (WB_ENTRY_W)
  ) storage (
    .clk     (clk),
    .load    (accept),
    .index   (store_index),
    .datain  (store_entry),
    .dataout (slots)
  );

  assign lookup_entry = lc3b_wb_entry'(slots[lookup_m.idx]);
  assign lookup_hit   = lookup_m.hit;
  assign lookup_data  = lookup_m.hit ? lookup_entry.data : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (alloc && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !alloc) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= WB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One idle bubble separates consecutive write-backs.
  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE:  if (count != '0) state_next = WB_WRITE;
      WB_WRITE: if (pmem_resp)   state_next = WB_IDLE;
      default:  state_next = WB_IDLE;
    endcase
  end

  always_comb begin
    head_entry   = lc3b_wb_entry'(slots[head]);
    pmem_write   = (state == WB_WRITE);
    pmem_address = {head_entry.tag, 4'b0000};
    pmem_wdata   = head_entry.data;
  end

endmodule

// File: tb/tb_eviction_writeback_buffer.sv
// Scoreboard bench for eviction_writeback_buffer: a queue model of buffered
// lines predicts lookups, fullness and the order/content of every write-back.
module tb_eviction_writeback_buffer;
  import lc3b_types::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         evict_valid;
  logic [15:0]  evict_addr;
  logic [127:0] evict_data;
  logic         evict_ready;
  logic [15:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_write;
  logic         pmem_resp;
  logic         empty;
  logic         full;

  typedef struct packed {
    logic [11:0]  tag;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic model_busy;
  int   tests;
  int   fails;
  int   wb_count;

  eviction_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .evict_valid  (evict_valid),
    .evict_addr   (evict_addr),
    .evict_data   (evict_data),
    .evict_ready  (evict_ready),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [128:0] model_lookup(input logic [15:0] a);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].tag == a[15:4]) return {1'b1, exp_q[i].data};
    end
    return '0;
  endfunction

  // One clock: check the write-back scoreboard before the edge, then advance the model.
  task automatic tick();
    logic pre_busy, pop, accept, found;
    int   size_pre, start;
    pre_busy = model_busy;
    size_pre = exp_q.size();
    pop      = reset_n && pre_busy && pmem_resp;
    accept   = reset_n && evict_valid && (size_pre < DEPTH);
    if (reset_n) begin
      tests++;
      if (pmem_write !== pre_busy) begin
        fails++;
        $display("[TB] FAIL pmem_write: got %b expected %b at %0t", pmem_write, pre_busy, $time);
      end
    end
    if (pop) begin
      tests++;
      wb_count++;
      if (pmem_address !== {exp_q[0].tag, 4'b0000} || pmem_wdata !== exp_q[0].data) begin
        fails++;
        $display("[TB] FAIL writeback: got %h/%h expected %h/%h", pmem_address, pmem_wdata,
                 {exp_q[0].tag, 4'b0000}, exp_q[0].data);
      end
    end
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      model_busy = 1'b0;
    end else begin
      if (accept) begin
        found = 1'b0;
        start = pre_busy ? 1 : 0;
        for (int i = start; i < exp_q.size(); i++) begin
          if (exp_q[i].tag == evict_addr[15:4]) begin
            exp_q[i].data = evict_data;
            found = 1'b1;
          end
        end
        if (!found) exp_q.push_back('{tag: evict_addr[15:4], data: evict_data});
      end
      if (pop) void'(exp_q.pop_front());
      model_busy = pre_busy ? !pop : (size_pre != 0);
    end
    #1;
  endtask

  task automatic enqueue(input logic [15:0] a, input logic [127:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic drain();
    int cycles;
    cycles    = 0;
    pmem_resp = 1'b1;
    while ((exp_q.size() != 0 || model_busy) && cycles < 200) begin
      tick();
      cycles++;
    end
    pmem_resp = 1'b0;
    tests++;
    if (cycles >= 200) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d cycles required < 200", cycles);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    tests += 5;
    if (empty !== 1'b1)       begin fails++; $display("[TB] FAIL reset_empty: got %b required 1", empty); end
    if (full !== 1'b0)        begin fails++; $display("[TB] FAIL reset_full: got %b required 0", full); end
    if (evict_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b required 1", evict_ready); end
    if (pmem_write !== 1'b0)  begin fails++; $display("[TB] FAIL reset_write: got %b required 0", pmem_write); end
    if (lookup_hit !== 1'b0)  begin fails++; $display("[TB] FAIL reset_hit: got %b required 0", lookup_hit); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = {16{8'hA5}};
    enqueue(16'h1230, d);
    lookup_addr = 16'h1234;
    #1;
    tests++;
    if ({lookup_hit, lookup_data} !== {1'b1, d}) begin
      fails++;
      $display("[TB] FAIL single_lookup: got %b/%h required 1/%h", lookup_hit, lookup_data, d);
    end
    tick();
    tests++;
    if (pmem_write !== 1'b1 || pmem_address !== 16'h1230) begin
      fails++;
      $display("[TB] FAIL single_write: got %b/%h required 1/1230", pmem_write, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1 || lookup_hit !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_done: got empty=%b hit=%b required 1/0", empty, lookup_hit);
    end
  endtask

  task automatic test_fill();
    int wb_start;
    wb_start = wb_count;
    for (int i = 0; i < DEPTH; i++) enqueue(16'h4000 + 16'(i * 16), {4{$urandom}});
    tests++;
    if (full !== 1'b1 || evict_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fill_full: got full=%b ready=%b required 1/0", full, evict_ready);
    end
    enqueue(16'h5000, {4{$urandom}});
    lookup_addr = 16'h5000;
    #1;
    tests++;
    if (full !== 1'b1 || lookup_hit !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fill_reject: got full=%b hit=%b required 1/0", full, lookup_hit);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tests++;
    if (full !== 1'b0 || evict_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fill_free: got full=%b ready=%b required 0/1", full, evict_ready);
    end
    drain();
    tests++;
    if (wb_count - wb_start !== DEPTH || empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fill_drain: got %0d writes empty=%b required %0d/1", wb_count - wb_start, empty, DEPTH);
    end
  endtask

  task automatic test_merge();
    logic [127:0] d1, d3, d4;
    logic [128:0] exp_l;
    int wb_start;
    wb_start = wb_count;
    d1 = {4{$urandom}};
    d3 = {4{$urandom}};
    d4 = {4{$urandom}};
    enqueue(16'h2000, d1);
    enqueue(16'h3000, {4{$urandom}});
    enqueue(16'h3008, d3);
    lookup_addr = 16'h3000;
    #1;
    exp_l = model_lookup(16'h3000);
    tests++;
    if ({lookup_hit, lookup_data} !== exp_l || exp_l[127:0] !== d3) begin
      fails++;
      $display("[TB] FAIL merge_lookup: got %b/%h required %h", lookup_hit, lookup_data, exp_l);
    end
    enqueue(16'h2000, d4);
    lookup_addr = 16'h2000;
    #1;
    exp_l = model_lookup(16'h2000);
    tests++;
    if ({lookup_hit, lookup_data} !== exp_l || exp_l[127:0] !== d4) begin
      fails++;
      $display("[TB] FAIL merge_youngest: got %b/%h required %h", lookup_hit, lookup_data, exp_l);
    end
    tests++;
    if (pmem_write !== 1'b1 || pmem_wdata !== d1) begin
      fails++;
      $display("[TB] FAIL merge_stable: got %b/%h required 1/%h", pmem_write, pmem_wdata, d1);
    end
    drain();
    tests++;
    if (wb_count - wb_start !== 3) begin
      fails++;
      $display("[TB] FAIL merge_count: got %0d writes required 3", wb_count - wb_start);
    end
  endtask

  task automatic test_simultaneous();
    int wb_start;
    wb_start = wb_count;
    for (int i = 0; i < 3; i++) enqueue(16'h6000 + 16'(i * 16), {4{$urandom}});
    pmem_resp = 1'b1;
    enqueue(16'h6030, {4{$urandom}});
    pmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) enqueue(16'h6040 + 16'(i * 16), {4{$urandom}});
    tests++;
    if (full !== 1'b0) begin
      fails++;
      $display("[TB] FAIL simul_seven: got full=%b required 0", full);
    end
    enqueue(16'h6080, {4{$urandom}});
    tests++;
    if (full !== 1'b1) begin
      fails++;
      $display("[TB] FAIL simul_eight: got full=%b required 1", full);
    end
    drain();
    tests++;
    if (wb_count - wb_start !== 9) begin
      fails++;
      $display("[TB] FAIL simul_count: got %0d writes required 9", wb_count - wb_start);
    end
  endtask

  task automatic test_wrap();
    int wb_start;
    wb_start = wb_count;
    for (int i = 0; i < 12; i++) begin
      enqueue(16'h7000 + 16'(i * 16), {4{$urandom}});
      drain();
      lookup_addr = 16'h7000 + 16'(i * 16);
      #1;
      tests++;
      if (lookup_hit !== 1'b0 || empty !== 1'b1) begin
        fails++;
        $display("[TB] FAIL wrap_%0d: got hit=%b empty=%b required 0/1", i, lookup_hit, empty);
      end
    end
    tests++;
    if (wb_count - wb_start !== 12) begin
      fails++;
      $display("[TB] FAIL wrap_count: got %0d writes required 12", wb_count - wb_start);
    end
  endtask

  task automatic test_reset_mid();
    enqueue(16'h8000, {4{$urandom}});
    enqueue(16'h8010, {4{$urandom}});
    tests++;
    if (pmem_write !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_busy: got %b required 1", pmem_write);
    end
    reset_n = 1'b0;
    tick();
    tests += 2;
    if (pmem_write !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset: got write=%b empty=%b required 0/1", pmem_write, empty);
    end
    lookup_addr = 16'h8000;
    #1;
    if (lookup_hit !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_hit0: got %b required 0", lookup_hit);
    end
    lookup_addr = 16'h8010;
    #1;
    tests++;
    if (lookup_hit !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_hit1: got %b required 0", lookup_hit);
    end
    reset_n = 1'b1;
    tick();
    tick();
    tests++;
    if (pmem_write !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_after: got write=%b empty=%b required 0/1", pmem_write, empty);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    wb_count    = 0;
    model_busy  = 1'b0;
    reset_n     = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    lookup_addr = '0;
    pmem_resp   = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_merge();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
